// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
// Module      : inst_encoder
// Description : Encodes an RV32 instruction description (format, opcode,
//               register fields, funct fields, immediate) into a 32-bit
//               instruction word. Illegal requests are replaced by the
//               canonical NOP (32'h00000013) and flagged with out_err.
//               Encoded words pass through a DEPTH-entry FIFO with
//               valid/ready handshakes on both sides.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               in_valid / in_ready  - request handshake
//               fmt, opcode, rd, rs1, rs2, funct3, funct7, imm
//                                    - instruction description
//               out_valid / out_ready- output handshake
//               out_inst, out_err    - head word and its substitution flag
//               inst_count           - accepted requests (wraps)
//               err_count            - accepted erroneous requests (saturates)
// Revision    : 1.0 - initial release
// ============================================================================
module inst_encoder #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [4:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [20:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_err,
    output logic [15:0] inst_count,
    output logic [7:0]  err_count
);

    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [2:0]  c_FMT_R   = 3'd0;
    localparam logic [2:0]  c_FMT_I   = 3'd1;
    localparam logic [2:0]  c_FMT_S   = 3'd2;
    localparam logic [2:0]  c_FMT_B   = 3'd3;
    localparam logic [2:0]  c_FMT_J   = 3'd4;
    localparam logic [2:0]  c_FMT_NOP = 3'd5;
    localparam logic [31:0] c_NOP     = 32'h00000013;

    // ------------------------------------------------------------------
    // Encoder
    // ------------------------------------------------------------------
    logic        w_legal;
    logic        w_err;
    logic [31:0] w_word;
    logic [32:0] w_entry;

    always_comb begin
        w_legal = 1'b0;
        w_word  = c_NOP;
        case (fmt)
            c_FMT_R: begin
                w_legal = (opcode == 5'b01100);
                w_word  = {funct7, rs2, rs1, funct3, rd, opcode, 2'b11};
            end
            c_FMT_I: begin
                w_legal = (opcode == 5'b00100) || (opcode == 5'b11001) ||
                          (opcode == 5'b00000);
                w_word  = {imm[11:0], rs1, funct3, rd, opcode, 2'b11};
            end
            c_FMT_S: begin
                w_legal = (opcode == 5'b01000);
                w_word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode, 2'b11};
            end
            c_FMT_B: begin
                w_legal = (opcode == 5'b11000);
                w_word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1],
                           imm[11], opcode, 2'b11};
            end
            c_FMT_J: begin
                w_legal = (opcode == 5'b11011);
                w_word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd,
                           opcode, 2'b11};
            end
            c_FMT_NOP: begin
                w_legal = 1'b1;
                w_word  = c_NOP;
            end
            default: begin
                w_legal = 1'b0;
                w_word  = c_NOP;
            end
        endcase
    end

    // Branch and jump targets must be halfword aligned.
    assign w_err   = !w_legal || (((fmt == c_FMT_B) || (fmt == c_FMT_J)) && imm[0]);
    assign w_entry = w_err ? {1'b1, c_NOP} : {1'b0, w_word};

    // ------------------------------------------------------------------
    // Output FIFO: a shift-down array whose slot 0 is the head. Slot 0 is
    // only overwritten by a shift or a write, so it keeps the last word
    // when the buffer drains.
    // ------------------------------------------------------------------
    logic [32:0]   r_slot [DEPTH];
    logic [CW-1:0] r_count;
    logic [15:0]   r_inst_count;
    logic [7:0]    r_err_count;

    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_wr_idx;

    assign in_ready  = (r_count < CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    // On a simultaneous pop the entries move down one place, so the new
    // word lands one slot lower than the current occupancy.
    assign w_wr_idx  = w_pop ? (r_count - CW'(1)) : r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count      <= '0;
            r_inst_count <= '0;
            r_err_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_slot[i] <= {1'b0, c_NOP};
            end
        end else begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (w_pop && ((CW'(i) + CW'(1)) < r_count)) begin
                    r_slot[i] <= r_slot[i + 1];
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (w_push && (w_wr_idx == CW'(i))) begin
                    r_slot[i] <= w_entry;
                end
            end
            r_count      <= r_count + CW'(w_push) - CW'(w_pop);
            r_inst_count <= r_inst_count + 16'(w_push);
            if (w_push && w_err && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign out_inst   = r_slot[0][31:0];
    assign out_err    = r_slot[0][32];
    assign inst_count = r_inst_count;
    assign err_count  = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_encoder
// Description : Self-checking bench for inst_encoder (DEPTH=2): vector table
//               of known encodings, hand-written handshake/reset sequences,
//               and a randomized run against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_encoder;

    localparam int          DEPTH = 2;
    localparam logic [31:0] c_NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [4:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [20:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic [15:0] inst_count;
    logic [7:0]  err_count;

    inst_encoder #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fmt        (fmt),
        .opcode     (opcode),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .funct3     (funct3),
        .funct7     (funct7),
        .imm        (imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inst   (out_inst),
        .out_err    (out_err),
        .inst_count (inst_count),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] f, input logic [4:0] op, input logic [4:0] d,
                           input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [20:0] im);
        fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
        funct3 = f3; funct7 = f7; imm = im;
    endtask

    // ---------------- reference model ----------------
    // Legal {fmt, opcode} pairs.
    logic [7:0] legal_pairs [7];
    initial begin
        legal_pairs[0] = {3'd0, 5'b01100};
        legal_pairs[1] = {3'd1, 5'b00100};
        legal_pairs[2] = {3'd1, 5'b11001};
        legal_pairs[3] = {3'd1, 5'b00000};
        legal_pairs[4] = {3'd2, 5'b01000};
        legal_pairs[5] = {3'd3, 5'b11000};
        legal_pairs[6] = {3'd4, 5'b11011};
    end

    // Returns {err, word}.
    function automatic logic [32:0] model_encode(
        input logic [2:0] f, input logic [4:0] op, input logic [4:0] d,
        input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
        input logic [6:0] f7, input logic [20:0] im);
        bit          legal = 0;
        logic [31:0] w;
        if (f == 3'd5) return {1'b0, c_NOP};
        foreach (legal_pairs[k]) if (legal_pairs[k] == {f, op}) legal = 1;
        if (!legal) return {1'b1, c_NOP};
        if ((f == 3'd3 || f == 3'd4) && im[0]) return {1'b1, c_NOP};
        case (f)
            3'd0:    w = {f7, s2, s1, f3, d, op, 2'b11};
            3'd1:    w = {im[11:0], s1, f3, d, op, 2'b11};
            3'd2:    w = {im[11:5], s2, s1, f3, im[4:0], op, 2'b11};
            3'd3:    w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op, 2'b11};
            default: w = {im[20], im[10:1], im[11], im[19:12], d, op, 2'b11};
        endcase
        return {1'b0, w};
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0]  f;
        logic [4:0]  op;
        logic [4:0]  d;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [20:0] im;
        logic [31:0] word;
        logic        err;
    } vec_t;

    vec_t tbl [12];

    logic [32:0] mq [$];
    logic [31:0] m_last;
    int          m_cnt;
    int          m_ecnt;

    initial begin
        tbl[0]  = '{3'd0, 5'b01100, 5'd1,  5'd2, 5'd3,  3'd0, 7'h20, 21'h0,      32'h403100B3, 1'b0};
        tbl[1]  = '{3'd3, 5'b11000, 5'd0,  5'd1, 5'd2,  3'd0, 7'h00, 21'h1FFFFC, 32'hFE208EE3, 1'b0};
        tbl[2]  = '{3'd3, 5'b11000, 5'd0,  5'd1, 5'd2,  3'd0, 7'h00, 21'h1FFFFD, c_NOP,        1'b1};
        tbl[3]  = '{3'd1, 5'b01100, 5'd1,  5'd2, 5'd0,  3'd0, 7'h00, 21'h5,      c_NOP,        1'b1};
        tbl[4]  = '{3'd5, 5'b10101, 5'd7,  5'd9, 5'd11, 3'd5, 7'h55, 21'h12345,  c_NOP,        1'b0};
        tbl[5]  = '{3'd1, 5'b00100, 5'd1,  5'd2, 5'd0,  3'd0, 7'h00, 21'h5,      32'h00510093, 1'b0};
        tbl[6]  = '{3'd2, 5'b01000, 5'd0,  5'd1, 5'd2,  3'd2, 7'h00, 21'h8,      32'h0020A423, 1'b0};
        tbl[7]  = '{3'd4, 5'b11011, 5'd1,  5'd0, 5'd0,  3'd0, 7'h00, 21'h8,      32'h008000EF, 1'b0};
        tbl[8]  = '{3'd1, 5'b11001, 5'd0,  5'd1, 5'd0,  3'd0, 7'h00, 21'h0,      32'h00008067, 1'b0};
        tbl[9]  = '{3'd6, 5'b01100, 5'd1,  5'd2, 5'd3,  3'd0, 7'h00, 21'h0,      c_NOP,        1'b1};
        tbl[10] = '{3'd4, 5'b11011, 5'd1,  5'd0, 5'd0,  3'd0, 7'h00, 21'h9,      c_NOP,        1'b1};
        tbl[11] = '{3'd1, 5'b00100, 5'd1,  5'd2, 5'd0,  3'd0, 7'h00, 21'h1FF005, 32'h00510093, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        set_req(3'd5, 5'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 21'd0);

        // ---- reset state ----
        step(); step();
        check("rst_out_valid",  out_valid,  0);
        check("rst_out_inst",   out_inst,   c_NOP);
        check("rst_out_err",    out_err,    0);
        check("rst_inst_count", inst_count, 0);
        check("rst_err_count",  err_count,  0);
        rst = 1'b0;
        step();
        check("rst_in_ready", in_ready, 1);

        // ---- table vectors, one at a time with out_ready=1 ----
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            set_req(tbl[i].f, tbl[i].op, tbl[i].d, tbl[i].s1, tbl[i].s2,
                    tbl[i].f3, tbl[i].f7, tbl[i].im);
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            check($sformatf("vec%0d_valid", i), out_valid, 1);
            check($sformatf("vec%0d_inst", i),  out_inst,  tbl[i].word);
            check($sformatf("vec%0d_err", i),   out_err,   tbl[i].err);
            check($sformatf("vec%0d_icnt", i),  inst_count, i + 1);
            step();
            check($sformatf("vec%0d_drained", i), out_valid, 0);
        end
        check("tbl_err_count", err_count, 4);

        // ---- backpressure: 3 back-to-back requests, consumer stalled ----
        rst = 1'b1; step(); rst = 1'b0;
        out_ready = 1'b0;
        set_req(3'd1, 5'b00100, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 21'd1);
        in_valid = 1'b1;
        step();
        check("bp_valid1", out_valid, 1);
        check("bp_inst1",  out_inst,  32'h00110093);
        check("bp_ready1", in_ready,  1);
        imm = 21'd2;
        step();
        check("bp_ready_full", in_ready, 0);
        check("bp_inst_hold0", out_inst, 32'h00110093);
        imm = 21'd3;
        step(); step();
        check("bp_ready_full2", in_ready, 0);
        check("bp_inst_hold1",  out_inst, 32'h00110093);
        check("bp_valid_hold",  out_valid, 1);
        out_ready = 1'b1;
        step();
        check("bp_inst2",   out_inst, 32'h00210093);
        check("bp_ready2",  in_ready, 1);
        step();
        check("bp_inst3",   out_inst,  32'h00310093);
        check("bp_valid3",  out_valid, 1);
        in_valid = 1'b0;
        step();
        check("bp_empty",      out_valid,  0);
        check("bp_empty_hold", out_inst,   32'h00310093);
        check("bp_icnt",       inst_count, 3);

        // ---- reset while full, with accept and removal requested ----
        out_ready = 1'b0;
        in_valid  = 1'b1;
        imm       = 21'd1;
        step(); step();
        check("full_ready", in_ready, 0);
        rst = 1'b1; out_ready = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        check("rf_valid", out_valid,  0);
        check("rf_icnt",  inst_count, 0);
        check("rf_ecnt",  err_count,  0);
        check("rf_ready", in_ready,   1);
        check("rf_inst",  out_inst,   c_NOP);

        // ---- err_count saturation ----
        set_req(3'd7, 5'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 21'd0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        repeat (300) step();
        in_valid = 1'b0;
        check("sat_ecnt", err_count,  8'hFF);
        check("sat_icnt", inst_count, 300);
        check("sat_err",  out_err,    1);

        // ---- randomized run against the reference model ----
        rst = 1'b1; step(); rst = 1'b0;
        mq.delete(); m_last = c_NOP; m_cnt = 0; m_ecnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit          m_acc;
            bit          m_pop;
            logic [32:0] m_entry;
            rst       = ($urandom_range(0, 99) == 0);
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 9) < 6;
            set_req(3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                    3'($urandom), 7'($urandom), 21'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                int k = $urandom_range(0, 6);
                fmt    = legal_pairs[k][7:5];
                opcode = legal_pairs[k][4:0];
            end
            m_acc   = in_valid && (mq.size() < DEPTH);
            m_pop   = out_ready && (mq.size() > 0);
            m_entry = model_encode(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);
            step();
            if (rst) begin
                mq.delete(); m_last = c_NOP; m_cnt = 0; m_ecnt = 0;
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_acc) begin
                    mq.push_back(m_entry);
                    m_cnt = (m_cnt + 1) % 65536;
                    if (m_entry[32] && m_ecnt < 255) m_ecnt++;
                end
            end
            if (mq.size() > 0) m_last = mq[0][31:0];
            check("rnd_valid", out_valid, mq.size() > 0);
            check("rnd_inst",  out_inst,  m_last);
            if (mq.size() > 0) check("rnd_err", out_err, mq[0][32]);
            check("rnd_ready", in_ready,   mq.size() < DEPTH);
            check("rnd_icnt",  inst_count, m_cnt);
            check("rnd_ecnt",  err_count,  m_ecnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
